// File: rtl/sseg_scan.sv
// Refresh controller for a 4-digit seven-segment display: rotates the active digit
// and tear-proofs value updates through a shadow register applied only at frame boundaries.
module sseg_scan #(
  parameter int DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic        hex_dec_in,
  input  logic        sign_in,
  output logic [15:0] data,
  output logic        hex_dec,
  output logic        sign,
  output logic [1:0]  digit_sel,
  output logic        tick,
  output logic        frame_done,
  output logic        pending
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    digit_q, digit_d;
  logic          tick_q, tick_d;
  logic          frame_q, frame_d;
  logic [15:0]   shData_q, shData_d;
  logic          shHex_q, shHex_d;
  logic          shSign_q, shSign_d;
  logic          pend_q, pend_d;
  logic [15:0]   dispData_q, dispData_d;
  logic          dispHex_q, dispHex_d;
  logic          dispSign_q, dispSign_d;

  logic advance;
  logic boundary;

  assign advance  = en && (cnt_q == CNT_MAX);
  assign boundary = advance && (digit_q == 2'd3);

  // A load on the boundary edge bypasses the shadow so it is visible in the same frame.
  always_comb begin
    cnt_d      = cnt_q;
    digit_d    = digit_q;
    tick_d     = advance;
    frame_d    = boundary;
    shData_d   = shData_q;
    shHex_d    = shHex_q;
    shSign_d   = shSign_q;
    pend_d     = pend_q;
    dispData_d = dispData_q;
    dispHex_d  = dispHex_q;
    dispSign_d = dispSign_q;

    if (en) begin
      cnt_d = advance ? '0 : cnt_q + CW'(1);
    end
    if (advance) begin
      digit_d = digit_q + 2'd1;
    end

    if (load) begin
      shData_d = data_in;
      shHex_d  = hex_dec_in;
      shSign_d = sign_in;
      pend_d   = 1'b1;
    end

    if (boundary) begin
      pend_d = 1'b0;
      if (load) begin
        dispData_d = data_in;
        dispHex_d  = hex_dec_in;
        dispSign_d = sign_in;
      end else if (pend_q) begin
        dispData_d = shData_q;
        dispHex_d  = shHex_q;
        dispSign_d = shSign_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      digit_q    <= 2'd0;
      tick_q     <= 1'b0;
      frame_q    <= 1'b0;
      shData_q   <= 16'h0000;
      shHex_q    <= 1'b0;
      shSign_q   <= 1'b0;
      pend_q     <= 1'b0;
      dispData_q <= 16'h0000;
      dispHex_q  <= 1'b0;
      dispSign_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      digit_q    <= digit_d;
      tick_q     <= tick_d;
      frame_q    <= frame_d;
      shData_q   <= shData_d;
      shHex_q    <= shHex_d;
      shSign_q   <= shSign_d;
      pend_q     <= pend_d;
      dispData_q <= dispData_d;
      dispHex_q  <= dispHex_d;
      dispSign_q <= dispSign_d;
    end
  end

  assign data       = dispData_q;
  assign hex_dec    = dispHex_q;
  assign sign       = dispSign_q;
  assign digit_sel  = digit_q;
  assign tick       = tick_q;
  assign frame_done = frame_q;
  assign pending    = pend_q;

endmodule

// File: tb/tb_sseg_scan.sv
// Scoreboard bench for sseg_scan: the driver predicts every cycle's outputs from
// edge counts and a load history, a monitor compares them against the DUT.
module tb_sseg_scan;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data_in = 16'h0000;
  logic        hex_dec_in = 1'b0;
  logic        sign_in = 1'b0;
  logic [15:0] data;
  logic        hex_dec;
  logic        sign;
  logic [1:0]  digit_sel;
  logic        tick;
  logic        frame_done;
  logic        pending;

  sseg_scan #(.DIV(DIV)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load),
    .data_in(data_in), .hex_dec_in(hex_dec_in), .sign_in(sign_in),
    .data(data), .hex_dec(hex_dec), .sign(sign), .digit_sel(digit_sel),
    .tick(tick), .frame_done(frame_done), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  digit;
    logic        tick;
    logic        frame;
    logic [15:0] data;
    logic        hexDec;
    logic        sign;
    logic        pending;
  } outRec_t;

  typedef struct {
    int          edgeIdx;
    logic [17:0] val;
  } loadRec_t;

  outRec_t  expQ[$];
  loadRec_t loads[$];

  int total = 0;
  int bad = 0;
  int enEdges = 0;
  int edgeIdx = 0;
  int lastBoundary = -1;
  int ticksSeen = 0;
  int framesSeen = 0;
  bit sawFFFF = 1'b0;

  // Reference model: outputs follow from how many enabled edges have passed since
  // reset and which load was the newest at or before the latest frame boundary.
  task automatic applyStimulus(input logic r, input logic e, input logic l,
                               input logic [15:0] d, input logic h, input logic s);
    outRec_t exp;
    rst = r; en = e; load = l; data_in = d; hex_dec_in = h; sign_in = s;
    exp = '0;
    if (r) begin
      enEdges = 0;
      edgeIdx = 0;
      lastBoundary = -1;
      loads.delete();
    end else begin
      edgeIdx++;
      if (l) loads.push_back('{edgeIdx, {h, s, d}});
      if (e) begin
        enEdges++;
        if (enEdges % DIV == 0) exp.tick = 1'b1;
        if (enEdges % (4 * DIV) == 0) begin
          exp.frame = 1'b1;
          lastBoundary = edgeIdx;
        end
      end
      exp.digit = 2'((enEdges / DIV) % 4);
      foreach (loads[i]) begin
        if (loads[i].edgeIdx <= lastBoundary) {exp.hexDec, exp.sign, exp.data} = loads[i].val;
        else exp.pending = 1'b1;
      end
    end
    @(posedge clk);
    expQ.push_back(exp);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: every cycle the registered outputs are compared against the oldest prediction.
  initial begin
    outRec_t act, exp;
    forever begin
      @(negedge clk);
      if (tick === 1'b1) ticksSeen++;
      if (frame_done === 1'b1) framesSeen++;
      if (data === 16'hFFFF) sawFFFF = 1'b1;
      if (expQ.size() > 0) begin
        exp = expQ.pop_front();
        act = {digit_sel, tick, frame_done, data, hex_dec, sign, pending};
        checkOutput("cycle_outputs", 32'(act), 32'(exp));
      end
    end
  end

  initial begin
    int t0, f0;
    logic r, e, l;

    // Reset then rotation: first tick after DIV edges, 10 ticks and 2 frames in 40 cycles.
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    @(negedge clk); #1;
    t0 = ticksSeen; f0 = framesSeen;
    idle(40);
    @(negedge clk); #1;
    checkOutput("rotation_ticks", 32'(ticksSeen - t0), 32'd10);
    checkOutput("rotation_frames", 32'(framesSeen - f0), 32'd2);

    // Mid-frame load while digit 1 is active.
    while ((enEdges / DIV) % 4 != 1) idle(1);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h1234, 1'b1, 1'b0);
    while (enEdges % (4 * DIV) != 0) idle(1);
    idle(2);

    // Two loads in one frame, then a load on the boundary edge itself.
    idle(3);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'hAAAA, 1'b0, 1'b1);
    idle(2);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h5555, 1'b1, 1'b0);
    while (enEdges % (4 * DIV) != 0) idle(1);
    while (enEdges % (4 * DIV) != 4 * DIV - 1) idle(1);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0F0F, 1'b0, 1'b0);
    idle(2);

    // Enable freeze at digit 2, cnt 2, with a load while frozen.
    while (enEdges % (4 * DIV) != 2 * DIV + 2) idle(1);
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b0, 1'b0, (i == 3), 16'hBEEF, 1'b1, 1'b1);
    idle(20);

    // Reset with a concurrent load while a value is pending.
    while ((enEdges / DIV) % 4 != 1) idle(1);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h7777, 1'b0, 1'b0);
    idle(2);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1);
    idle(40);
    @(negedge clk); #1;
    checkOutput("reset_blocks_ffff", 32'(sawFFFF), 32'd0);

    // Randomized traffic including occasional resets and enable gaps.
    for (int i = 0; i < 800; i++) begin
      r = ($urandom_range(0, 99) == 0);
      e = ($urandom_range(0, 7) != 0);
      l = ($urandom_range(0, 5) == 0);
      applyStimulus(r, e, l, 16'($urandom), 1'($urandom), 1'($urandom));
    end

    @(negedge clk);
    @(negedge clk); #1;
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
